// File: rtl/exe_fwd_ctrl.sv
// EXE-stage operand forwarding and load-use hazard control.
// Tracks MEM/WB destination tags internally and counts stall cycles.
module exe_fwd_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rt,
  input  logic [4:0]  nrs,
  input  logic [4:0]  nrt,
  input  logic [4:0]  drw,
  input  logic        nreg_write,
  input  logic [1:0]  ns_data_write,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        stall,
  output logic        flush_ex,
  output logic [15:0] stall_cnt
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] BUBBLE = 1'b1;

  logic [0:0]  r_state;
  logic [4:0]  r_mem_rw;
  logic        r_mem_we;
  logic        r_mem_ld;
  logic [4:0]  r_wb_rw;
  logic        r_wb_we;
  logic [15:0] r_stall_cnt;

  logic        w_is_load;
  logic        w_hazard;
  logic        w_stall;
  logic [0:0]  w_state_nx;
  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;

  assign w_is_load = (ns_data_write == 2'b01);

  assign w_hazard = nreg_write && (drw != 5'd0) && w_is_load &&
                    ((drw == id_rs) || (id_use_rt && (drw == id_rt)));

  // Gate with reset so a stall drops the instant reset is raised.
  assign w_stall = (r_state == RUN) && w_hazard && !reset;

  // A load sitting in MEM is never forwarded; the stall keeps that case away.
  assign w_fwd_a =
    (nrs == 5'd0)                                 ? 2'b00 :
    (r_mem_we && !r_mem_ld && (r_mem_rw == nrs))  ? 2'b01 :
    (r_wb_we && (r_wb_rw == nrs))                 ? 2'b10 :
                                                    2'b00;

  assign w_fwd_b =
    (nrt == 5'd0)                                 ? 2'b00 :
    (r_mem_we && !r_mem_ld && (r_mem_rw == nrt))  ? 2'b01 :
    (r_wb_we && (r_wb_rw == nrt))                 ? 2'b10 :
                                                    2'b00;

  always_comb begin
    w_state_nx = RUN;
    unique case (r_state)
      RUN:     w_state_nx = w_hazard ? BUBBLE : RUN;
      BUBBLE:  w_state_nx = RUN;
      default: w_state_nx = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= RUN;
      r_mem_rw <= 5'd0;
      r_mem_we <= 1'b0;
      r_mem_ld <= 1'b0;
      r_wb_rw  <= 5'd0;
      r_wb_we  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_mem_rw <= drw;
      r_mem_we <= nreg_write && (drw != 5'd0);
      r_mem_ld <= w_is_load;
      r_wb_rw  <= r_mem_rw;
      r_wb_we  <= r_mem_we;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= 16'd0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign fwd_a     = w_fwd_a;
  assign fwd_b     = w_fwd_b;
  assign stall     = w_stall;
  assign flush_ex  = w_stall;
  assign stall_cnt = r_stall_cnt;

endmodule
